// File: rtl/int_div_pkg.sv
// Shared definitions for the APU integer divider: operator encodings and FSM states.
package riscv_defines_apu;

  localparam logic [1:0] DIV_DIV  = 2'b00;
  localparam logic [1:0] DIV_DIVU = 2'b01;
  localparam logic [1:0] DIV_REM  = 2'b10;
  localparam logic [1:0] DIV_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIV    = 2'b01,
    FINISH = 2'b10
  } div_state_e;

endpackage

// File: rtl/int_div_lzc.sv
// Leading-zero counter with all-zero flag; count equals WIDTH when the input is zero.
module int_div_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       data_i,
  output logic [$clog2(WIDTH):0] count_o,
  output logic                   zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Scan upward so the highest set bit wins the final assignment.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      count_o = data_i[i] ? CNT_W'(WIDTH - 1 - i) : count_o;
    end
  end

  assign zero_o = ~(|data_i);

endmodule

// File: rtl/int_div.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Optional INT_DIV_EARLY_TERM_EN skips the dividend's leading zeros.
module int_div
  import riscv_defines_apu::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             req_i,
  output logic             gnt_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  div_state_e       state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r, dvd_r, dvs_r;
  logic [1:0]       op_r;
  logic             neg_q_r, neg_r_r;
  logic             valid_r;
  logic [WIDTH-1:0] result_r;

  logic             accept_s, signed_op_s, a_neg_s, b_neg_s;
  logic             div0_s, ovf_s, zero_skip_s, special_s;
  logic [WIDTH-1:0] abs_a_s, abs_b_s, dvd_init_s;
  logic [CNT_W-1:0] cnt_init_s;
  logic [WIDTH:0]   trial_s;
  logic             qbit_s;
  logic [WIDTH-1:0] rem_step_s, quot_fix_s, rem_fix_s, res_s;

  assign gnt_o    = req_i & (state_r != DIV);
  assign accept_s = gnt_o;

  assign signed_op_s = (operator_i == DIV_DIV) | (operator_i == DIV_REM);
  assign a_neg_s     = signed_op_s & op_a_i[WIDTH-1];
  assign b_neg_s     = signed_op_s & op_b_i[WIDTH-1];
  assign abs_a_s     = a_neg_s ? twos_neg(op_a_i) : op_a_i;
  assign abs_b_s     = b_neg_s ? twos_neg(op_b_i) : op_b_i;
  assign div0_s      = (op_b_i == ZERO_W);
  assign ovf_s       = signed_op_s & (op_a_i == MSB_ONLY) & (op_b_i == ALL_ONES);

`ifdef INT_DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lzc_s;
  logic             a_zero_s;

  int_div_lzc #(.WIDTH(WIDTH)) u_lzc (
    .data_i  (abs_a_s),
    .count_o (lzc_s),
    .zero_o  (a_zero_s)
  );

  // Leading zeros only ever yield zero quotient bits, so they are skipped outright.
  assign dvd_init_s  = abs_a_s << lzc_s;
  assign cnt_init_s  = CNT_W'(WIDTH) - lzc_s;
  assign zero_skip_s = a_zero_s;
`else
  assign dvd_init_s  = abs_a_s;
  assign cnt_init_s  = CNT_W'(WIDTH);
  assign zero_skip_s = 1'b0;
`endif

  assign special_s = div0_s | ovf_s | zero_skip_s;

  // One restoring step; the dividend register collects quotient bits from the LSB.
  assign trial_s    = {rem_r, dvd_r[WIDTH-1]} - {1'b0, dvs_r};
  assign qbit_s     = ~trial_s[WIDTH];
  assign rem_step_s = qbit_s ? trial_s[WIDTH-1:0] : {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
  assign quot_fix_s = neg_q_r ? twos_neg(dvd_r) : dvd_r;
  assign rem_fix_s  = neg_r_r ? twos_neg(rem_r) : rem_r;
  assign res_s      = ((op_r == DIV_DIV) || (op_r == DIV_DIVU)) ? quot_fix_s : rem_fix_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, FINISH: begin
        if (accept_s) begin
          state_next_s = special_s ? FINISH : DIV;
        end else begin
          state_next_s = IDLE;
        end
      end
      DIV: begin
        if (cnt_r == CNT_ONE) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = DIV;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= CNT_ZERO;
      rem_r    <= ZERO_W;
      dvd_r    <= ZERO_W;
      dvs_r    <= ZERO_W;
      op_r     <= 2'b00;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= ZERO_W;
    end else begin
      if (accept_s) begin
        op_r <= operator_i;
        if (special_s) begin
          // Special results are preloaded as unsigned quotient/remainder, no fix-up.
          dvd_r   <= div0_s ? ALL_ONES : (ovf_s ? MSB_ONLY : ZERO_W);
          rem_r   <= div0_s ? op_a_i : ZERO_W;
          dvs_r   <= ZERO_W;
          neg_q_r <= 1'b0;
          neg_r_r <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end else begin
          dvd_r   <= dvd_init_s;
          rem_r   <= ZERO_W;
          dvs_r   <= abs_b_s;
          neg_q_r <= a_neg_s ^ b_neg_s;
          neg_r_r <= a_neg_s;
          cnt_r   <= cnt_init_s;
        end
      end else if (state_r == DIV) begin
        rem_r <= rem_step_s;
        dvd_r <= {dvd_r[WIDTH-2:0], qbit_s};
        cnt_r <= cnt_r - CNT_ONE;
      end
      valid_r <= (state_r == FINISH);
      if (state_r == FINISH) begin
        result_r <= res_s;
      end
    end
  end

  assign valid_o  = valid_r;
  assign result_o = result_r;
  assign busy_o   = (state_r != IDLE);

endmodule
